// File: rtl/sbox_share_arbiter_pkg.sv
// Shared definitions for the S-box sharing arbiter: port IDs, defaults, tag type
// and the AES S-box lookup used by the S4 word-substitution unit.
package sbox_share_arbiter_pkg;

    localparam int unsigned WORD_W            = 32;
    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned N_PORTS           = 2;
    localparam int unsigned BURST_MAX_DEFAULT = 4;
    localparam bit          OUT_REG_DEFAULT   = 1'b0;
    localparam int unsigned LATENCY_DEFAULT   = OUT_REG_DEFAULT ? 2 : 1;

    typedef enum logic {
        PORT_ROUND = 1'b0,
        PORT_KEY   = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e id;
    } tag_t;

    function automatic int unsigned latency(input bit out_reg);
        return out_reg ? 2 : 1;
    endfunction

    // Entry 0x00 sits in the most significant byte, so index by the inverted byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [BYTE_W-1:0] sbox_byte(input logic [BYTE_W-1:0] b);
        return SBOX_TBL[{~b, 3'b000} +: BYTE_W];
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

endpackage

// File: rtl/sbox_share_arbiter_if.sv
// Request/response bundle between the two S-box requesters and the arbiter.
interface sbox_share_arbiter_if;

    logic                                      req0_valid;
    logic                                      req0_last;
    logic [sbox_share_arbiter_pkg::WORD_W-1:0] req0_word;
    logic                                      req0_ready;
    logic                                      req1_valid;
    logic [sbox_share_arbiter_pkg::WORD_W-1:0] req1_word;
    logic                                      req1_ready;
    logic                                      rsp0_valid;
    logic [sbox_share_arbiter_pkg::WORD_W-1:0] rsp0_word;
    logic                                      rsp1_valid;
    logic [sbox_share_arbiter_pkg::WORD_W-1:0] rsp1_word;
    logic                                      idle;

    modport master (
        output req0_valid, req0_last, req0_word, req1_valid, req1_word,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_word,
               rsp1_valid, rsp1_word, idle
    );

    modport slave (
        input  req0_valid, req0_last, req0_word, req1_valid, req1_word,
        output req0_ready, req1_ready, rsp0_valid, rsp0_word,
               rsp1_valid, rsp1_word, idle
    );

endinterface

// File: rtl/sbox_share_arbiter_s4.sv
// S4 unit: four parallel AES S-boxes with a single unreset output register.
module sbox_share_arbiter_s4
    import sbox_share_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              i_en,
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word
);

    logic [WORD_W-1:0] r_word;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_word <= sub_word(i_word);
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/sbox_share_arbiter.sv
// Shares one S4 unit between the round datapath (port 0, lockable bursts) and the
// key schedule (port 1); tags each lookup and returns it at fixed latency.
module sbox_share_arbiter
    import sbox_share_arbiter_pkg::*;
#(
    parameter bit          OUT_REG   = OUT_REG_DEFAULT,
    parameter int unsigned BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sbox_share_arbiter_if.slave  bus
);

    localparam int unsigned LAT   = latency(OUT_REG);
    localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

    logic              r_lock;
    port_id_e          r_rr_ptr;
    logic [CNT_W-1:0]  r_burst_cnt;
    tag_t              r_tag1;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;
    logic [WORD_W-1:0] w_s4_in;
    logic [WORD_W-1:0] w_s4_out;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_burst_full;
    tag_t              w_tag_out;
    logic [WORD_W-1:0] w_rsp_word;
    logic              w_pipe_busy;

    // Grant: lock pins the unit to port 0, otherwise round-robin on contention.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_lock) begin
            w_gnt0 = bus.req0_valid;
        end else if (bus.req0_valid && bus.req1_valid) begin
            w_gnt0 = (r_rr_ptr == PORT_ROUND);
            w_gnt1 = (r_rr_ptr == PORT_KEY);
        end else begin
            w_gnt0 = bus.req0_valid;
            w_gnt1 = bus.req1_valid;
        end
    end

    assign w_accept     = w_gnt0 | w_gnt1;
    assign w_s4_in      = w_gnt1 ? bus.req1_word : bus.req0_word;
    assign w_cnt_next   = r_burst_cnt + CNT_W'(1);
    assign w_burst_full = (w_cnt_next == CNT_W'(BURST_MAX));

    // Burst lock, burst length counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock      <= 1'b0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= PORT_ROUND;
        end else if (w_gnt0) begin
            r_rr_ptr <= PORT_KEY;
            if (bus.req0_last || w_burst_full) begin
                r_lock      <= 1'b0;
                r_burst_cnt <= '0;
            end else begin
                r_lock      <= 1'b1;
                r_burst_cnt <= w_cnt_next;
            end
        end else if (w_gnt1) begin
            r_rr_ptr <= PORT_ROUND;
        end
    end

    sbox_share_arbiter_s4 u_s4 (
        .clk    (clk),
        .i_en   (w_accept),
        .i_word (w_s4_in),
        .o_word (w_s4_out)
    );

    // First tag stage travels alongside the S4 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag1.valid <= 1'b0;
            r_tag1.id    <= PORT_ROUND;
        end else begin
            r_tag1.valid <= w_accept;
            r_tag1.id    <= w_gnt1 ? PORT_KEY : PORT_ROUND;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            tag_t              r_tag2;
            logic [WORD_W-1:0] r_word2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag2.valid <= 1'b0;
                    r_tag2.id    <= PORT_ROUND;
                end else begin
                    r_tag2 <= r_tag1;
                end
            end

            always_ff @(posedge clk) begin
                if (r_tag1.valid) begin
                    r_word2 <= w_s4_out;
                end
            end

            assign w_tag_out   = r_tag2;
            assign w_rsp_word  = r_word2;
            assign w_pipe_busy = r_tag1.valid | r_tag2.valid;
        end else begin : g_no_out_reg
            assign w_tag_out   = r_tag1;
            assign w_rsp_word  = w_s4_out;
            assign w_pipe_busy = r_tag1.valid;
        end
    endgenerate

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.rsp0_valid = w_tag_out.valid & (w_tag_out.id == PORT_ROUND);
    assign bus.rsp1_valid = w_tag_out.valid & (w_tag_out.id == PORT_KEY);
    assign bus.rsp0_word  = w_rsp_word;
    assign bus.rsp1_word  = w_rsp_word;
    assign bus.idle       = ~w_accept & ~w_pipe_busy;

    a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_gnt0 && w_gnt1));
    a_gnt0_valid : assert property (@(posedge clk) disable iff (!rst_n)
        w_gnt0 |-> bus.req0_valid);
    a_gnt1_valid : assert property (@(posedge clk) disable iff (!rst_n)
        w_gnt1 |-> bus.req1_valid);
    a_lock_blocks_key : assert property (@(posedge clk) disable iff (!rst_n)
        r_lock |-> !w_gnt1);
    a_latency_ok : assert property (@(posedge clk) disable iff (!rst_n)
        (LAT == 1) || (LAT == 2));

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Directed bench for sbox_share_arbiter: latency-1 instance (A) and latency-2 instance (B).
module tb_sbox_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a;
    logic rst_n_b;

    sbox_share_arbiter_if if_a ();
    sbox_share_arbiter_if if_b ();

    sbox_share_arbiter #(.OUT_REG(1'b0), .BURST_MAX(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (if_a.slave)
    );

    sbox_share_arbiter #(.OUT_REG(1'b1), .BURST_MAX(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (if_b.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v0, input logic last, input logic [31:0] w0,
                           input logic v1, input logic [31:0] w1);
        if_a.req0_valid = v0;
        if_a.req0_last  = last;
        if_a.req0_word  = w0;
        if_a.req1_valid = v1;
        if_a.req1_word  = w1;
    endtask

    task automatic drive_b(input logic v0, input logic last, input logic [31:0] w0,
                           input logic v1, input logic [31:0] w1);
        if_b.req0_valid = v0;
        if_b.req0_last  = last;
        if_b.req0_word  = w0;
        if_b.req1_valid = v1;
        if_b.req1_word  = w1;
    endtask

    // One cycle on A: exp_g is the expected granted port (2 = none), exp_w its response.
    task automatic step_a(input logic v0, input logic last, input logic [31:0] w0,
                          input logic v1, input logic [31:0] w1,
                          input int exp_g, input logic [31:0] exp_w, input string tag);
        @(negedge clk);
        drive_a(v0, last, w0, v1, w1);
        #1;
        chk({tag, ".ready0"}, 32'(if_a.req0_ready), 32'(exp_g == 0));
        chk({tag, ".ready1"}, 32'(if_a.req1_ready), 32'(exp_g == 1));
        @(posedge clk);
        #1;
        chk({tag, ".rsp0_valid"}, 32'(if_a.rsp0_valid), 32'(exp_g == 0));
        chk({tag, ".rsp1_valid"}, 32'(if_a.rsp1_valid), 32'(exp_g == 1));
        if (exp_g == 0) chk({tag, ".rsp0_word"}, if_a.rsp0_word, exp_w);
        if (exp_g == 1) chk({tag, ".rsp1_word"}, if_a.rsp1_word, exp_w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_b(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst.idle",       32'(if_a.idle),       32'd1);
        chk("rst.ready0",     32'(if_a.req0_ready), 32'd0);
        chk("rst.ready1",     32'(if_a.req1_ready), 32'd0);
        chk("rst.rsp0_valid", 32'(if_a.rsp0_valid), 32'd0);
        chk("rst.rsp1_valid", 32'(if_a.rsp1_valid), 32'd0);
        chk("rst_b.idle",     32'(if_b.idle),       32'd1);
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Port 1 alone, latency 1.
        step_a(1'b0, 1'b0, 32'h0, 1'b1, 32'h00010203, 1, 32'h637c777b, "t1");
        @(negedge clk);
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("t1.idle_busy", 32'(if_a.idle), 32'd0);
        @(posedge clk);
        #1;
        chk("t1.rsp1_drop", 32'(if_a.rsp1_valid), 32'd0);
        chk("t1.idle_done", 32'(if_a.idle), 32'd1);

        // Both valid every cycle: strict alternation starting at port 0.
        step_a(1'b1, 1'b1, 32'h53535353, 1'b1, 32'h0, 0, 32'hedededed, "t2.c0");
        step_a(1'b1, 1'b1, 32'h53535353, 1'b1, 32'h0, 1, 32'h63636363, "t2.c1");
        step_a(1'b1, 1'b1, 32'h53535353, 1'b1, 32'h0, 0, 32'hedededed, "t2.c2");
        step_a(1'b1, 1'b1, 32'h53535353, 1'b1, 32'h0, 1, 32'h63636363, "t2.c3");
        step_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2, 32'h0, "t2.drain");

        // Locked burst of 4 ending with last, port 1 waiting throughout.
        step_a(1'b1, 1'b0, 32'h00010203, 1'b1, 32'h02020202, 0, 32'h637c777b, "t3.c0");
        step_a(1'b1, 1'b0, 32'h53535353, 1'b1, 32'h02020202, 0, 32'hedededed, "t3.c1");
        step_a(1'b1, 1'b0, 32'h00000000, 1'b1, 32'h02020202, 0, 32'h63636363, "t3.c2");
        step_a(1'b1, 1'b1, 32'h01010101, 1'b1, 32'h02020202, 0, 32'h7c7c7c7c, "t3.c3");
        step_a(1'b1, 1'b1, 32'h53535353, 1'b1, 32'h02020202, 1, 32'h77777777, "t3.c4");
        step_a(1'b1, 1'b1, 32'h53535353, 1'b1, 32'h02020202, 0, 32'hedededed, "t3.c5");
        step_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2, 32'h0, "t3.drain");

        // No last: forced release after 4 words; port 0 gap keeps port 1 starved.
        step_a(1'b1, 1'b0, 32'h0, 1'b0, 32'h00010203, 0, 32'h63636363, "t4.c0");
        step_a(1'b0, 1'b0, 32'h0, 1'b1, 32'h00010203, 2, 32'h0,        "t4.gap");
        step_a(1'b1, 1'b0, 32'h0, 1'b1, 32'h00010203, 0, 32'h63636363, "t4.c2");
        step_a(1'b1, 1'b0, 32'h0, 1'b1, 32'h00010203, 0, 32'h63636363, "t4.c3");
        step_a(1'b1, 1'b0, 32'h0, 1'b1, 32'h00010203, 0, 32'h63636363, "t4.c4");
        step_a(1'b1, 1'b0, 32'h0, 1'b1, 32'h00010203, 1, 32'h637c777b, "t4.c5");
        step_a(1'b1, 1'b0, 32'h0, 1'b1, 32'h00010203, 0, 32'h63636363, "t4.c6");
        step_a(1'b0, 1'b0, 32'h0, 1'b1, 32'h00010203, 2, 32'h0,        "t4.lock_held");

        // Reset while locked: lock must clear.
        @(negedge clk);
        rst_n_a = 1'b0;
        drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("t5.idle_in_rst", 32'(if_a.idle), 32'd1);
        @(negedge clk);
        rst_n_a = 1'b1;
        step_a(1'b0, 1'b0, 32'h0, 1'b1, 32'h00010203, 1, 32'h637c777b, "t5.unlock");
        step_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2, 32'h0, "t5.drain");

        // OUT_REG = 1: port 1 alone, response two cycles after accept.
        @(negedge clk);
        drive_b(1'b0, 1'b0, 32'h0, 1'b1, 32'h00010203);
        #1;
        chk("t6.ready1", 32'(if_b.req1_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("t6.rsp1_early", 32'(if_b.rsp1_valid), 32'd0);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("t6.idle_busy", 32'(if_b.idle), 32'd0);
        @(posedge clk);
        #1;
        chk("t6.rsp1_valid", 32'(if_b.rsp1_valid), 32'd1);
        chk("t6.rsp1_word",  if_b.rsp1_word, 32'h637c777b);
        @(posedge clk);
        #1;
        chk("t6.rsp1_pulse", 32'(if_b.rsp1_valid), 32'd0);
        chk("t6.idle_done",  32'(if_b.idle), 32'd1);

        // OUT_REG = 1: reset with two lookups in flight, rr pointer left at port 1.
        @(negedge clk);
        drive_b(1'b1, 1'b1, 32'h53535353, 1'b0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n_b = 1'b0;
        drive_b(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("t7.rsp0_in_rst", 32'(if_b.rsp0_valid), 32'd0);
        chk("t7.idle_in_rst", 32'(if_b.idle), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t7.no_rsp0", 32'(if_b.rsp0_valid), 32'd0);
            chk("t7.no_rsp1", 32'(if_b.rsp1_valid), 32'd0);
        end
        @(negedge clk);
        rst_n_b = 1'b1;
        drive_b(1'b1, 1'b0, 32'h53535353, 1'b1, 32'h0);
        #1;
        chk("t7.post_ready0", 32'(if_b.req0_ready), 32'd1);
        chk("t7.post_ready1", 32'(if_b.req1_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t7.post_rsp0_early", 32'(if_b.rsp0_valid), 32'd0);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("t7.post_rsp0_valid", 32'(if_b.rsp0_valid), 32'd1);
        chk("t7.post_rsp0_word",  if_b.rsp0_word, 32'hedededed);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
